// File: rtl/ethpipe_tx_pkg.sv
// ethpipe_tx_pkg
// Shared definitions for the TX frame path: the fixed header layout that
// the host stages in front of every frame (read back by the GMII sender)
// and the state encoding of the slot-memory admission FSM.
// No ports; imported by tx_slot_arbiter and the sender.
package ethpipe_tx_pkg;

  // Every staged frame starts with this many 16-bit header words
  localparam int TX_HDR_WORDS      = 7;
  localparam int TX_HDR_LEN_IDX    = 0;
  localparam int TX_HDR_TS0_IDX    = 1;
  localparam int TX_HDR_TS1_IDX    = 2;
  localparam int TX_HDR_TS2_IDX    = 3;
  localparam int TX_HDR_TS3_IDX    = 4;
  localparam int TX_HDR_HASH0_IDX  = 5;
  localparam int TX_HDR_HASH1_IDX  = 6;

  // Width of the per-frame word counter; comfortably above any frame limit
  localparam int ARB_CNT_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_FILL = 2'd1,
    ARB_DROP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/tx_slot_arbiter.sv
// tx_slot_arbiter
// Owns the single-port TX frame slot memory and shares it between the host
// write path and the GMII sender read path. The sender always wins. Host
// frames are staged behind the committed write pointer, which only moves
// once a complete frame of legal length has been written, so the sender
// never observes a partial frame.
// Ports:
//   gmii_tx_clk / sys_rst          clock, synchronous active-high reset
//   host_wr_*  / host_abort        host word stream (valid/ready) and abort
//   snd_rd_en / snd_rd_addr        sender read request
//   snd_rd_q  / snd_rd_valid       sender read data, one cycle later
//   mem_*                          slot memory port (1-cycle read latency)
//   mem_wr_ptr / mem_rd_ptr        committed write pointer, released read ptr
//   txfifo_free_space_ratio        [0] free >= DEPTH/2, [1] free >= DEPTH/4
//   frames_committed / _dropped    frame statistics (dropped saturates)
module tx_slot_arbiter
  import ethpipe_tx_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int MIN_FRAME_WORDS = TX_HDR_WORDS + 1,
  parameter int MAX_FRAME_WORDS = 766
) (
  input  logic              gmii_tx_clk,
  input  logic              sys_rst,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [15:0]       host_wr_data,
  input  logic [1:0]        host_wr_byte_en,
  input  logic              host_wr_last,
  input  logic              host_abort,
  input  logic              snd_rd_en,
  input  logic [ADDR_W-1:0] snd_rd_addr,
  output logic [15:0]       snd_rd_q,
  output logic              snd_rd_valid,
  output logic              mem_en,
  output logic              mem_wr_en,
  output logic [1:0]        mem_byte_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  input  logic [15:0]       mem_q,
  output logic [ADDR_W-1:0] mem_wr_ptr,
  input  logic [ADDR_W-1:0] mem_rd_ptr,
  output logic [1:0]        txfifo_free_space_ratio,
  output logic [31:0]       frames_committed,
  output logic [15:0]       frames_dropped
);

  localparam logic [ADDR_W-1:0] FREE_HALF    = ADDR_W'(1) << (ADDR_W - 1);
  localparam logic [ADDR_W-1:0] FREE_QUARTER = ADDR_W'(1) << (ADDR_W - 2);
  localparam logic [ARB_CNT_W-1:0] MIN_WORDS = ARB_CNT_W'(MIN_FRAME_WORDS);
  localparam logic [ARB_CNT_W-1:0] MAX_WORDS = ARB_CNT_W'(MAX_FRAME_WORDS);

  arb_state_e           state_q, state_d;
  logic [ADDR_W-1:0]    stagePtr_q, stagePtr_d;
  logic [ADDR_W-1:0]    wrPtr_q, wrPtr_d;
  logic [ARB_CNT_W-1:0] wordCnt_q, wordCnt_d;
  logic [ARB_CNT_W-1:0] wordCntInc;
  logic [ADDR_W-1:0]    stagePtrInc;
  logic [ADDR_W-1:0]    usedWords;
  logic [ADDR_W-1:0]    freeWords;
  logic [1:0]           ratio_q, ratio_d;
  logic [31:0]          committed_q;
  logic [15:0]          dropped_q;
  logic                 sndRdValid_q;
  logic                 full;
  logic                 rdGrant;
  logic                 accept;
  logic                 doWrite;
  logic                 commitFrame;
  logic                 dropFrame;

  assign stagePtrInc = stagePtr_q + 1'b1;
  assign wordCntInc  = wordCnt_q + 1'b1;

  // One slot is always left empty so that stage == rd means "empty"
  assign full = (stagePtrInc == mem_rd_ptr);

  // While dropping, words go nowhere, so a full memory must not stall them
  assign host_wr_ready = ~sys_rst & ~snd_rd_en & ~host_abort &
                         (~full | (state_q == ARB_DROP));
  assign accept  = host_wr_valid & host_wr_ready;
  assign rdGrant = snd_rd_en & ~sys_rst;

  // DEPTH-1 minus the used count is just its bitwise complement
  assign usedWords = stagePtr_q - mem_rd_ptr;
  assign freeWords = ~usedWords;
  assign ratio_d   = {freeWords >= FREE_QUARTER, freeWords >= FREE_HALF};

  // Admission FSM, pointer bookkeeping and memory port steering
  always_comb begin
    state_d     = state_q;
    stagePtr_d  = stagePtr_q;
    wrPtr_d     = wrPtr_q;
    wordCnt_d   = wordCnt_q;
    doWrite     = 1'b0;
    commitFrame = 1'b0;
    dropFrame   = 1'b0;
    mem_en      = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = stagePtr_q;
    mem_data    = 16'h0000;
    mem_byte_en = 2'b00;

    if (host_abort) begin
      stagePtr_d = wrPtr_q;
      wordCnt_d  = '0;
      state_d    = ARB_IDLE;
      dropFrame  = (state_q != ARB_IDLE);
    end else if (accept) begin
      unique case (state_q)
        ARB_IDLE: begin
          doWrite = 1'b1;
          if (host_wr_last) begin
            // A single-word frame is a runt: the write lands but is orphaned
            stagePtr_d = wrPtr_q;
            wordCnt_d  = '0;
            dropFrame  = 1'b1;
          end else begin
            stagePtr_d = stagePtrInc;
            wordCnt_d  = ARB_CNT_W'(1);
            state_d    = ARB_FILL;
          end
        end
        ARB_FILL: begin
          if (wordCntInc > MAX_WORDS) begin
            stagePtr_d = wrPtr_q;
            wordCnt_d  = '0;
            if (host_wr_last) begin
              dropFrame = 1'b1;
              state_d   = ARB_IDLE;
            end else begin
              state_d = ARB_DROP;
            end
          end else begin
            doWrite    = 1'b1;
            stagePtr_d = stagePtrInc;
            wordCnt_d  = wordCntInc;
            if (host_wr_last) begin
              wordCnt_d = '0;
              state_d   = ARB_IDLE;
              if (wordCntInc >= MIN_WORDS) begin
                wrPtr_d     = stagePtrInc;
                commitFrame = 1'b1;
              end else begin
                stagePtr_d = wrPtr_q;
                dropFrame  = 1'b1;
              end
            end
          end
        end
        ARB_DROP: begin
          if (host_wr_last) begin
            dropFrame = 1'b1;
            state_d   = ARB_IDLE;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end

    // Host writes and sender reads never coincide: ready is low while reading
    if (rdGrant) begin
      mem_en   = 1'b1;
      mem_addr = snd_rd_addr;
    end else if (doWrite) begin
      mem_en      = 1'b1;
      mem_wr_en   = 1'b1;
      mem_addr    = stagePtr_q;
      mem_data    = host_wr_data;
      mem_byte_en = host_wr_byte_en;
    end
  end

  // State, pointers, statistics and registered status outputs
  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) begin
      state_q      <= ARB_IDLE;
      stagePtr_q   <= '0;
      wrPtr_q      <= '0;
      wordCnt_q    <= '0;
      ratio_q      <= 2'b11;
      committed_q  <= '0;
      dropped_q    <= '0;
      sndRdValid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stagePtr_q   <= stagePtr_d;
      wrPtr_q      <= wrPtr_d;
      wordCnt_q    <= wordCnt_d;
      ratio_q      <= ratio_d;
      sndRdValid_q <= snd_rd_en;
      if (commitFrame) begin
        committed_q <= committed_q + 1'b1;
      end
      if (dropFrame && (dropped_q != 16'hFFFF)) begin
        dropped_q <= dropped_q + 1'b1;
      end
    end
  end

  assign snd_rd_q                = mem_q;
  assign snd_rd_valid            = sndRdValid_q;
  assign mem_wr_ptr              = wrPtr_q;
  assign txfifo_free_space_ratio = ratio_q;
  assign frames_committed        = committed_q;
  assign frames_dropped          = dropped_q;

endmodule

// File: tb/tb_tx_slot_arbiter.sv
// tb_tx_slot_arbiter
// Scoreboard bench for tx_slot_arbiter with a 16-word slot memory model.
// Expected memory writes and sender read data are queued when stimulus is
// issued; a negedge monitor pops and compares whenever the DUT writes the
// memory or presents snd_rd_valid.
module tb_tx_slot_arbiter;

  localparam int AW   = 4;
  localparam int MINW = 8;
  localparam int MAXW = 766;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          host_wr_valid = 1'b0;
  logic          host_wr_ready;
  logic [15:0]   host_wr_data = 16'h0;
  logic [1:0]    host_wr_byte_en = 2'b00;
  logic          host_wr_last = 1'b0;
  logic          host_abort = 1'b0;
  logic          snd_rd_en = 1'b0;
  logic [AW-1:0] snd_rd_addr = '0;
  logic [15:0]   snd_rd_q;
  logic          snd_rd_valid;
  logic          mem_en;
  logic          mem_wr_en;
  logic [1:0]    mem_byte_en;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic [15:0]   mem_q = 16'h0;
  logic [AW-1:0] mem_wr_ptr;
  logic [AW-1:0] mem_rd_ptr = '0;
  logic [1:0]    txfifo_free_space_ratio;
  logic [31:0]   frames_committed;
  logic [15:0]   frames_dropped;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
    logic [1:0]  be;
  } wrExp_t;

  wrExp_t      wrQ[$];
  logic [15:0] rdQ[$];
  logic [15:0] memArray [16];

  int          testCount = 0;
  int          failCount = 0;
  logic [3:0]  expStage = '0;
  logic [3:0]  expWrPtr = '0;
  int          expCommitted = 0;
  int          expDropped = 0;

  always #5 clk = ~clk;

  tx_slot_arbiter #(
    .ADDR_W          (AW),
    .MIN_FRAME_WORDS (MINW),
    .MAX_FRAME_WORDS (MAXW)
  ) dut (
    .gmii_tx_clk             (clk),
    .sys_rst                 (sys_rst),
    .host_wr_valid           (host_wr_valid),
    .host_wr_ready           (host_wr_ready),
    .host_wr_data            (host_wr_data),
    .host_wr_byte_en         (host_wr_byte_en),
    .host_wr_last            (host_wr_last),
    .host_abort              (host_abort),
    .snd_rd_en               (snd_rd_en),
    .snd_rd_addr             (snd_rd_addr),
    .snd_rd_q                (snd_rd_q),
    .snd_rd_valid            (snd_rd_valid),
    .mem_en                  (mem_en),
    .mem_wr_en               (mem_wr_en),
    .mem_byte_en             (mem_byte_en),
    .mem_addr                (mem_addr),
    .mem_data                (mem_data),
    .mem_q                   (mem_q),
    .mem_wr_ptr              (mem_wr_ptr),
    .mem_rd_ptr              (mem_rd_ptr),
    .txfifo_free_space_ratio (txfifo_free_space_ratio),
    .frames_committed        (frames_committed),
    .frames_dropped          (frames_dropped)
  );

  // Single-port slot memory with byte enables and one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) begin
        if (mem_byte_en[0]) memArray[mem_addr][7:0]  <= mem_data[7:0];
        if (mem_byte_en[1]) memArray[mem_addr][15:8] <= mem_data[15:8];
      end else begin
        mem_q <= memArray[mem_addr];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] wordData(input int tag, input int i);
    return 16'((tag << 8) | (i & 255));
  endfunction

  // Monitor: every memory write and every sender read beat is scored
  always @(negedge clk) begin
    wrExp_t e;
    logic [15:0] r;
    if (mem_en === 1'b1 && mem_wr_en === 1'b1) begin
      if (wrQ.size() == 0) begin
        testCount++;
        failCount++;
        $display("[TB] FAIL unexpectedWrite: got write addr %0h data %0h, want none",
                 mem_addr, mem_data);
      end else begin
        e = wrQ.pop_front();
        checkOutput("memWrite", {10'h0, mem_addr, mem_data, mem_byte_en},
                    {10'h0, e.addr, e.data, e.be});
      end
    end
    if (snd_rd_valid === 1'b1) begin
      if (rdQ.size() == 0) begin
        testCount++;
        failCount++;
        $display("[TB] FAIL unexpectedRead: got snd_rd_q %0h, want no beat", snd_rd_q);
      end else begin
        r = rdQ.pop_front();
        checkOutput("sndRdQ", {16'h0, snd_rd_q}, {16'h0, r});
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    host_wr_valid = 1'b0;
    host_wr_last  = 1'b0;
    host_abort    = 1'b0;
    snd_rd_en     = 1'b0;
  endtask

  task automatic checkCounters();
    @(negedge clk);
    checkOutput("memWrPtr", {28'h0, mem_wr_ptr}, {28'h0, expWrPtr});
    checkOutput("framesCommitted", frames_committed, expCommitted);
    checkOutput("framesDropped", {16'h0, frames_dropped}, expDropped);
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    sys_rst       = 1'b1;
    host_wr_valid = 1'b1;
    snd_rd_en     = 1'b1;
    host_abort    = 1'b0;
    host_wr_last  = 1'b0;
    mem_rd_ptr    = '0;
    @(negedge clk);
    checkOutput("readyInReset", {31'h0, host_wr_ready}, 0);
    checkOutput("memEnInReset", {31'h0, mem_en}, 0);
    @(posedge clk); #1;
    host_wr_valid = 1'b0;
    snd_rd_en     = 1'b0;
    @(posedge clk); #1;
    sys_rst      = 1'b0;
    expStage     = '0;
    expWrPtr     = '0;
    expCommitted = 0;
    expDropped   = 0;
    @(negedge clk);
    checkOutput("resetWrPtr", {28'h0, mem_wr_ptr}, 0);
    checkOutput("resetCommitted", frames_committed, 0);
    checkOutput("resetDropped", {16'h0, frames_dropped}, 0);
    checkOutput("resetRatio", {30'h0, txfifo_free_space_ratio}, 32'h3);
    checkOutput("resetRdValid", {31'h0, snd_rd_valid}, 0);
  endtask

  // Drive one word and hold it until accepted (bounded)
  task automatic applyStimulus(input logic [15:0] d, input logic [1:0] be,
                               input logic last, input bit expWrite,
                               input bit setRd, input logic [3:0] rdVal);
    int n;
    @(posedge clk); #1;
    if (setRd) mem_rd_ptr = rdVal;
    if (expWrite) begin
      wrQ.push_back('{addr: expStage, data: d, be: be});
      expStage = expStage + 4'd1;
    end
    host_wr_valid   = 1'b1;
    host_wr_data    = d;
    host_wr_byte_en = be;
    host_wr_last    = last;
    n = 0;
    @(negedge clk);
    while (host_wr_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wordAccepted", {31'h0, host_wr_ready}, 1);
  endtask

  task automatic sendFrame(input int tag, input int n, input bit autoRd);
    logic [3:0] rdVal;
    logic [1:0] be;
    for (int i = 1; i <= n; i++) begin
      if (i == MAXW + 1) expStage = expWrPtr;
      rdVal = (i <= MAXW) ? expStage + 4'd8 : expWrPtr + 4'd1;
      be    = (i == n) ? 2'b10 : 2'b11;
      applyStimulus(wordData(tag, i), be, (i == n), (i <= MAXW), autoRd, rdVal);
    end
    checkOutput("wrPtrBeforeCommit", {28'h0, mem_wr_ptr}, {28'h0, expWrPtr});
    if (n >= MINW && n <= MAXW) begin
      expWrPtr = expStage;
      expCommitted++;
    end else begin
      expStage = expWrPtr;
      expDropped++;
    end
    idle();
    checkCounters();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, want finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // 10-word frame: writes 0..9, pointer moves to 10 after the last write
    doReset();
    sendFrame(1, 10, 1'b0);

    // Sender holds the port for 5 cycles while the host is waiting
    @(posedge clk); #1;
    host_wr_valid = 1'b1;
    host_wr_data  = 16'hDEAD;
    host_wr_last  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      snd_rd_en   = 1'b1;
      snd_rd_addr = 4'(k);
      rdQ.push_back(wordData(1, k + 1));
      @(negedge clk);
      checkOutput("readyWhileReading", {31'h0, host_wr_ready}, 0);
      checkOutput("rdValidLag", {31'h0, snd_rd_valid}, (k > 0) ? 1 : 0);
      @(posedge clk); #1;
    end
    snd_rd_en     = 1'b0;
    host_wr_valid = 1'b0;
    @(negedge clk);
    checkOutput("rdValidTail", {31'h0, snd_rd_valid}, 1);
    @(negedge clk);
    checkOutput("rdValidDone", {31'h0, snd_rd_valid}, 0);

    // Free-space ratio: 9 committed words with rd=0 leaves 6 free
    doReset();
    sendFrame(4, 9, 1'b0);
    @(negedge clk);
    checkOutput("ratioNine", {30'h0, txfifo_free_space_ratio}, 32'h2);
    mem_rd_ptr = 4'd9;
    @(negedge clk);
    checkOutput("ratioDrained", {30'h0, txfifo_free_space_ratio}, 32'h3);

    // Full stall at stage 15, resume after the sender releases, wrap to 4
    doReset();
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(wordData(3, i), 2'b11, 1'b0, 1'b1, 1'b0, 4'd0);
    end
    @(posedge clk); #1;
    host_wr_data = wordData(3, 16);
    host_wr_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("fullStall", {31'h0, host_wr_ready}, 0);
    end
    host_wr_valid = 1'b0;
    mem_rd_ptr    = 4'd8;
    for (int i = 16; i <= 20; i++) begin
      applyStimulus(wordData(3, i), 2'b11, (i == 20), 1'b1, 1'b0, 4'd0);
    end
    checkOutput("wrPtrBeforeWrapCommit", {28'h0, mem_wr_ptr}, 0);
    expWrPtr = expStage;
    expCommitted++;
    idle();
    checkCounters();
    @(negedge clk);
    checkOutput("ratioAfterWrap", {30'h0, txfifo_free_space_ratio}, 32'h0);

    // Runt, oversize (DROP ignores full), abort, then minimum legal frame
    doReset();
    sendFrame(5, 5, 1'b0);
    sendFrame(6, 800, 1'b1);
    mem_rd_ptr = '0;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(wordData(7, i), 2'b11, 1'b0, 1'b1, 1'b0, 4'd0);
    end
    @(posedge clk); #1;
    host_wr_data  = wordData(7, 6);
    host_wr_valid = 1'b1;
    host_abort    = 1'b1;
    @(negedge clk);
    checkOutput("readyDuringAbort", {31'h0, host_wr_ready}, 0);
    expStage = expWrPtr;
    expDropped++;
    idle();
    checkCounters();
    sendFrame(8, 8, 1'b0);

    @(negedge clk);
    checkOutput("wrQueueDrained", wrQ.size(), 0);
    checkOutput("rdQueueDrained", rdQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
